// File: rtl/apo_node_injector_pkg.sv
// apo_node_injector_pkg: packet layout, injector FSM encoding and saturating counter helper
package apo_node_injector_pkg;
    localparam int PKT_W = 17;
    localparam int NODE_W = 8;
    localparam int VLD_BIT = 16;
    localparam int CNT_W = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} inj_state_t;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + 16'd1 : v;
    endfunction
endpackage

// File: rtl/apo_node_injector_if.sv
// apo_node_injector_if: host-side destination request handshake
interface apo_node_injector_if;
    import apo_node_injector_pkg::*;
    logic req_valid;
    logic [NODE_W-1:0] req_dest;
    logic req_ready;
    modport master(output req_valid, output req_dest, input req_ready);
    modport slave(input req_valid, input req_dest, output req_ready);
endinterface

// File: rtl/apo_pkt_fifo.sv
// apo_pkt_fifo: circular destination queue; occupancy carries one extra bit to tell full from empty
module apo_pkt_fifo
    import apo_node_injector_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [NODE_W-1:0] din,
    input  logic              pop,
    output logic [NODE_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);
    logic [NODE_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] occ;
    logic do_push, do_pop;
    assign full = occ == (AW+1)'(DEPTH);
    assign empty = occ == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            occ <= occ + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/apo_node_injector.sv
// apo_node_injector: queues host destinations and injects them one at a time, paced by an idle gap
module apo_node_injector
    import apo_node_injector_pkg::*;
#(
    parameter int N_COUNT = 196,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NODE_W-1:0]  router_name,
    apo_node_injector_if.slave req,
    output logic [PKT_W-1:0]   out_free,
    input  logic               in_data,
    output logic [CNT_W-1:0]   inj_count,
    output logic [CNT_W-1:0]   rcv_count,
    output logic [CNT_W-1:0]   err_count,
    output logic               busy
);
    inj_state_t state, state_nx;
    logic [3:0] gap_cnt, gap_nx;
    logic [PKT_W-1:0] out_nx;
    logic [NODE_W-1:0] head;
    logic full, empty, accept, legal, pop;
    logic unused_name;
    // own node number does not enter the packet; self-addressed requests are queued like any other
    assign unused_name = ^router_name;
    assign req.req_ready = !full;
    assign accept = req.req_valid && !full;
    assign legal = 32'(req.req_dest) < N_COUNT;
    assign busy = !empty || state != ST_IDLE;
    apo_pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(accept && legal),
        .din(req.req_dest),
        .pop(pop),
        .dout(head),
        .full(full),
        .empty(empty)
    );
    always_comb begin
        state_nx = state;
        gap_nx = gap_cnt;
        out_nx = '0;
        pop = 1'b0;
        case (state)
            ST_IDLE: begin
                pop = !empty;
                out_nx[VLD_BIT] = !empty;
                out_nx[NODE_W-1:0] = empty ? '0 : head;
                state_nx = empty ? ST_IDLE : ST_SEND;
            end
            ST_SEND: begin
                state_nx = (GAP > 0) ? ST_GAP : ST_IDLE;
                gap_nx = 4'(GAP);
            end
            ST_GAP: begin
                state_nx = (gap_cnt <= 4'd1) ? ST_IDLE : ST_GAP;
                gap_nx = (gap_cnt <= 4'd1) ? 4'd0 : gap_cnt - 4'd1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            gap_cnt <= '0;
            out_free <= '0;
            inj_count <= '0;
            rcv_count <= '0;
            err_count <= '0;
        end else begin
            state <= state_nx;
            gap_cnt <= gap_nx;
            out_free <= out_nx;
            inj_count <= sat_inc(inj_count, state == ST_SEND);
            rcv_count <= sat_inc(rcv_count, in_data);
            err_count <= sat_inc(err_count, accept && !legal);
        end
    end
endmodule

// File: tb/tb_apo_node_injector.sv
// tb_apo_node_injector: directed stimulus checked every cycle against a queue/cooldown reference model
module tb_apo_node_injector;
    import apo_node_injector_pkg::*;
    localparam int N_COUNT = 196;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst;
    logic in_data = 1'b0;
    logic [7:0] router_name = 8'd0;
    logic [16:0] out_free;
    logic [15:0] inj_count, rcv_count, err_count;
    logic busy;

    apo_node_injector_if bus();

    apo_node_injector #(.N_COUNT(N_COUNT), .FIFO_DEPTH(FIFO_DEPTH), .GAP(GAP)) dut (
        .clk(clk),
        .rst(rst),
        .router_name(router_name),
        .req(bus),
        .out_free(out_free),
        .in_data(in_data),
        .inj_count(inj_count),
        .rcv_count(rcv_count),
        .err_count(err_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // model: accepted legal destinations wait in q; after each injection no new packet may start for GAP+1 edges
    logic [7:0] q[$];
    int cool;
    logic [16:0] m_out;
    logic [15:0] m_inj, m_rcv, m_err;
    logic [7:0] seen[$];
    int seen_cyc[$];
    int cyc = 0;
    bit saw_full;
    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        cool = 0;
        m_out = '0;
        m_inj = '0;
        m_rcv = '0;
        m_err = '0;
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic model_step();
        bit rdy;
        if (rst) begin
            model_clear();
            return;
        end
        if (m_out[16]) m_inj = sat(m_inj);
        rdy = q.size() < FIFO_DEPTH;
        if (cool == 0 && q.size() > 0) begin
            m_out = {1'b1, 8'h00, q.pop_front()};
            cool = GAP + 1;
        end else begin
            m_out = '0;
            if (cool > 0) cool--;
        end
        if (bus.req_valid && rdy) begin
            if (int'(bus.req_dest) < N_COUNT) q.push_back(bus.req_dest);
            else m_err = sat(m_err);
        end
        if (in_data) m_rcv = sat(m_rcv);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst) begin
            check("out_free", 32'(out_free), 32'(m_out));
            check("req_ready", 32'(bus.req_ready), 32'(q.size() < FIFO_DEPTH));
            check("busy", 32'(busy), 32'(q.size() > 0 || cool > 0));
            check("inj_count", 32'(inj_count), 32'(m_inj));
            check("rcv_count", 32'(rcv_count), 32'(m_rcv));
            check("err_count", 32'(err_count), 32'(m_err));
            if (out_free[16]) begin
                seen.push_back(out_free[7:0]);
                seen_cyc.push_back(cyc);
            end
            if (!bus.req_ready) saw_full = 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_req(input logic [7:0] d);
        int b = 0;
        bus.req_valid = 1'b1;
        bus.req_dest = d;
        while (!bus.req_ready && b < 50) begin
            @(negedge clk);
            #1;
            b++;
        end
        check("push_ready_wait", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        #1;
        check("rst_out_free", 32'(out_free), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_inj", 32'(inj_count), 32'd0);
        check("rst_rcv", 32'(rcv_count), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        seen.delete();
        seen_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        bus.req_valid = 1'b0;
        bus.req_dest = 8'd0;
        model_clear();
        rst = 1'b0;
        #1 rst = 1'b1;
        do_reset();

        // single request: packet on the edge after acceptance, held one cycle
        push_req(8'd5);
        bus.req_valid = 1'b0;
        check("r36_wait_e1", 32'(out_free), 32'd0);
        idle(1);
        check("r36_out_free", 32'(out_free), 32'h10005);
        idle(1);
        check("r36_out_drop", 32'(out_free), 32'd0);
        check("r36_inj", 32'(inj_count), 32'd1);

        // out-of-range destination is counted and dropped
        push_req(8'd196);
        bus.req_valid = 1'b0;
        idle(6);
        check("r38_err", 32'(err_count), 32'd1);
        check("r38_inj", 32'(inj_count), 32'd1);
        check("r38_busy", 32'(busy), 32'd0);

        // six back-to-back requests into a four-deep queue
        seen.delete();
        seen_cyc.delete();
        saw_full = 1'b0;
        for (int i = 0; i < 6; i++) push_req(8'(10 + i));
        bus.req_valid = 1'b0;
        idle(30);
        check("r37_count", 32'(seen.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < seen.size()) check("r37_order", 32'(seen[i]), 32'(10 + i));
        if (seen_cyc.size() > 1) check("r37_spacing", 32'(seen_cyc[1] - seen_cyc[0]), 32'd4);
        check("r37_saw_full", 32'(saw_full), 32'd1);
        check("r37_inj", 32'(inj_count), 32'd7);

        // delivery pulses counted alongside an injection
        do_reset();
        push_req(8'd7);
        bus.req_valid = 1'b0;
        in_data = 1'b1;
        idle(3);
        in_data = 1'b0;
        check("r39_rcv", 32'(rcv_count), 32'd3);
        idle(8);
        check("r39_inj", 32'(inj_count), 32'd1);
        check("r39_pkt_count", 32'(seen.size()), 32'd1);
        if (seen.size() > 0) check("r39_pkt", 32'(seen[0]), 32'd7);

        // reset while a packet is on the wire with three more queued
        do_reset();
        for (int i = 0; i < 5; i++) push_req(8'(20 + i));
        bus.req_valid = 1'b0;
        b = 0;
        while (out_free !== 17'h10015 && b < 40) begin
            idle(1);
            b++;
        end
        check("r40_send_seen", 32'(out_free), 32'h10015);
        do_reset();
        idle(12);
        check("r40_no_pkts", 32'(seen.size()), 32'd0);
        check("r40_inj", 32'(inj_count), 32'd0);
        check("r40_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
